// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN-to-1 mux built from 4:1 stages, one register rank per tree level.
// The select is either the sel port (direct) or an internal round-robin counter (auto-scan).
module mux_tree_pipe #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         mode,
  input  logic [DATA_W*(2**SEL_W)-1:0] in,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         in_valid,
  output logic [DATA_W-1:0]            out,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_valid
);

  localparam int NUM_IN = 2 ** SEL_W;
  localparam int LEVELS = SEL_W / 2;

  // Number of tree nodes in levels 1..lvl-1; locates a level inside the flat node vector.
  function automatic int node_off(input int lvl);
    int n;
    n = 0;
    for (int i = 1; i < lvl; i++) n += NUM_IN / (4 ** i);
    return n;
  endfunction

  localparam int NODES = node_off(LEVELS + 1);

  function automatic logic [DATA_W-1:0] mux4(input logic [4*DATA_W-1:0] grp,
                                             input logic [1:0]          s);
    case (s)
      2'd0:    return grp[0*DATA_W +: DATA_W];
      2'd1:    return grp[1*DATA_W +: DATA_W];
      2'd2:    return grp[2*DATA_W +: DATA_W];
      default: return grp[3*DATA_W +: DATA_W];
    endcase
  endfunction

  logic [SEL_W-1:0]             cnt_q, cnt_d;
  logic [SEL_W-1:0]             esel;
  logic [NODES*DATA_W-1:0]      tree_q, tree_d;
  logic [LEVELS-1:0][SEL_W-1:0] sel_q;
  logic [LEVELS-1:0]            valid_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    esel  = mode ? cnt_q : sel;
    if (mode && in_valid) cnt_d = cnt_q + 1'b1;
  end

  for (genvar j = 1; j <= LEVELS; j++) begin : gen_lvl
    localparam int GRP  = NUM_IN / (4 ** j);
    localparam int OFF  = node_off(j);
    localparam int POFF = node_off(j - 1);
    for (genvar g = 0; g < GRP; g++) begin : gen_grp
      if (j == 1) begin : gen_leaf
        assign tree_d[(OFF+g)*DATA_W +: DATA_W] =
          mux4(in[4*g*DATA_W +: 4*DATA_W], esel[1:0]);
      end else begin : gen_node
        // Each sample steers the deeper levels with the select it carried in at level 1.
        assign tree_d[(OFF+g)*DATA_W +: DATA_W] =
          mux4(tree_q[(POFF+4*g)*DATA_W +: 4*DATA_W], sel_q[j-2][2*j-1 -: 2]);
      end
    end
  end

  // NOTE: the data ranks are reset too, because out must read 0 as soon as reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      tree_q  <= '0;
      sel_q   <= '0;
      valid_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every rank sample the pre-edge value of the one before it.
      cnt_q      <= cnt_d;
      tree_q     <= tree_d;
      sel_q[0]   <= esel;
      valid_q[0] <= in_valid;
      for (int j = 1; j < LEVELS; j++) begin
        sel_q[j]   <= sel_q[j-1];
        valid_q[j] <= valid_q[j-1];
      end
    end
  end

  assign out       = tree_q[(NODES-1)*DATA_W +: DATA_W];
  assign out_sel   = sel_q[LEVELS-1];
  assign out_valid = valid_q[LEVELS-1];

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
Parametrised, pipelined NUM_IN-to-1 multiplexer of DATA_W-bit channels, built as a tree of 4:1 stages with one register per tree level. It has two select modes: direct, where the select comes from the port, and auto-scan, where an internal round-robin counter supplies it. Each output sample carries a valid flag and the index of the channel it came from. It is the scalable successor to the fixed 16:1 bit mux and feeds downstream datapath and channel-monitor logic.

Parameters:
DATA_W, 8, width of each channel in bits (>=1)
SEL_W, 4, select width; must be even and >=2; NUM_IN = 2**SEL_W (4, 16, 64, ...)
LEVELS, SEL_W/2, derived; number of 4:1 tree levels, which equals the pipeline latency in cycles

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  pipeline advance enable; 0 freezes all registers, the counter and the outputs
mode  input  1  0 = direct select, 1 = auto-scan
in  input  DATA_W*2**SEL_W  packed channels; channel k occupies in[k*DATA_W +: DATA_W]
sel  input  SEL_W  channel index used in direct mode
in_valid  input  1  marks the input sample in this cycle as valid
out  output  DATA_W  selected channel data
out_sel  output  SEL_W  channel index that produced out
out_valid  output  1  out/out_sel hold a valid sample

Behaviour:
- Reset: asynchronous, active-high. It clears all pipeline data and select registers, all valid bits and the scan counter. out=0, out_sel=0, out_valid=0 immediately, with no clock edge needed. Asserting reset mid-operation discards every in-flight sample.
- Effective select esel: sel when mode=0; scan counter value when mode=1. mode is sampled on every accepted cycle, and a mode change applies to the next accepted sample only. Samples already in flight are unaffected.
- Acceptance: a cycle is accepted when en=1. On an accepted cycle, level 1 registers the 4:1 result of every channel group using esel[1:0]. The full esel and the in_valid bit are registered alongside that result.
- Level j (j=2..LEVELS) selects among 4 results of level j-1 using bits esel[2j-1:2j-2] of the select carried with the data. Higher select bits choose higher-indexed groups: channel k is selected when esel==k.
- Latency: a sample accepted at edge n appears on out/out_sel/out_valid after edge n+LEVELS-1, i.e. LEVELS accepted edges. Throughput is 1 sample per accepted cycle.
- en=0 (stall): no register changes, including the counter. Outputs hold their values and out_valid does not drop. Stalls extend latency by exactly the number of stall cycles.
- out_valid is the delayed in_valid. Samples with in_valid=0 still flow through the pipeline; out/out_sel are don't-care-but-deterministic while out_valid=0.
- Scan counter: SEL_W bits, reset 0. It increments by 1 on every cycle with en=1, in_valid=1 and mode=1. It wraps from 2**SEL_W-1 to 0.
- The counter holds its value when mode=0 and resumes from that value when mode returns to 1.
- Simultaneous mode=1 and in_valid=1: the current counter value is used as esel for that sample, and the counter then increments.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset/latency (DATA_W=8, SEL_W=4, LEVELS=2): assert reset, release, mode=0, en=1; channel k=8'hA0+k; sel=5, in_valid=1 for 1 cycle. Required: out=8'hA5, out_sel=5, out_valid=1 exactly 2 edges later, then out_valid=0.
2. Direct sweep: stream sel=0..15 back-to-back with in_valid=1. Required: out=A0..AF and out_sel=0..15 on consecutive cycles from edge 2, with out_valid held at 1.
3. Auto-scan wrap: mode=1 with in_valid=1 for 18 cycles. Required: out_sel sequence 0..15,0,1 and out=8'hA0+out_sel. Then in_valid=0 for 3 cycles; the counter holds and the next valid sample reports out_sel=2.
4. Stall: mid-stream, drop en for 3 cycles. Required: outputs and the counter frozen for 3 cycles, no samples lost or duplicated, and the order is preserved after en returns to 1.
5. Reset mid-operation: assert reset asynchronously between edges with 2 samples in flight. Required: out=0, out_sel=0, out_valid=0 immediately. The scan restarts at out_sel=0 after release.
6. Parameter sweep: SEL_W=2 (LEVELS=1, latency 1) and SEL_W=6 with DATA_W=1 (64:1, latency 3). Required: random sel/in results match the reference model at the stated latency for 1000 cycles.
